// File: rtl/object_track_ctrl.sv
// object_track_ctrl: frame-level search/confirm/lock/coast tracker sitting behind the rectangle detector.
// Samples centre/area on each vsync rising edge, qualifies it and publishes a smoothed track point.
module object_track_ctrl #(
  parameter int unsigned IMG_W     = 200,
  parameter int unsigned IMG_H     = 164,
  parameter int unsigned MIN_AREA  = 64,
  parameter int unsigned MAX_AREA  = 16000,
  parameter int unsigned CONFIRM_N = 3,
  parameter int unsigned LOST_N    = 4,
  parameter int unsigned MAX_JUMP  = 32,
  parameter int unsigned SMOOTH_SH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_enable,
  input  logic               i_vsync,
  input  logic signed [31:0] i_mid_x,
  input  logic signed [31:0] i_mid_y,
  input  logic signed [31:0] i_p_sum,
  output logic [10:0]        o_trk_x,
  output logic [10:0]        o_trk_y,
  output logic               o_trk_valid,
  output logic [2:0]         o_state,
  output logic               o_lost_pulse,
  output logic               o_det_clear,
  output logic [15:0]        o_frame_cnt
);

  localparam int unsigned CW  = 11;
  localparam int unsigned DW  = CW + 1;
  localparam int unsigned SW  = CW + 2;
  localparam int unsigned HCW = $clog2(CONFIRM_N + 1);
  localparam int unsigned MCW = $clog2(LOST_N + 1);
  localparam int unsigned FCW = 16;

  localparam logic signed [31:0]    MIN_A_S  = 32'(MIN_AREA);
  localparam logic signed [31:0]    MAX_A_S  = 32'(MAX_AREA);
  localparam logic signed [31:0]    IMG_W_S  = 32'(IMG_W);
  localparam logic signed [31:0]    IMG_H_S  = 32'(IMG_H);
  localparam logic signed [DW-1:0]  JUMP_S   = DW'(MAX_JUMP);
  localparam logic [CW-1:0]         X_MAX    = CW'(IMG_W - 1);
  localparam logic [CW-1:0]         Y_MAX    = CW'(IMG_H - 1);
  localparam logic [HCW-1:0]        HIT_LAST = HCW'(CONFIRM_N);
  localparam logic [MCW-1:0]        MISS_END = MCW'(LOST_N);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEARCH  = 3'd1,
    ST_CONFIRM = 3'd2,
    ST_LOCK    = 3'd3,
    ST_COAST   = 3'd4
  } state_e;

  state_e          state_q;
  logic            vsync_d_q;
  logic [CW-1:0]   cand_x_q, cand_y_q;
  logic [CW-1:0]   trk_x_q, trk_y_q;
  logic [HCW-1:0]  hit_cnt_q;
  logic [MCW-1:0]  miss_cnt_q;
  logic [FCW-1:0]  frame_cnt_q;
  logic            valid_q, lost_q, clear_q;

  logic            fe, hit, near_cand, near_trk;
  logic [CW-1:0]   meas_x, meas_y, iir_x, iir_y;

  // |a-b| <= MAX_JUMP on in-range coordinates
  function automatic logic near_f(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic signed [DW-1:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d <= JUMP_S) && (d >= -JUMP_S);
  endfunction

  // trk + ((meas - trk) >>> SMOOTH_SH), clamped to 0..maxv
  function automatic logic [CW-1:0] iir_f(input logic [CW-1:0] trk, input logic [CW-1:0] meas,
                                          input logic [CW-1:0] maxv);
    logic signed [DW-1:0] diff;
    logic signed [DW-1:0] step;
    logic signed [SW-1:0] sum;
    diff = $signed({1'b0, meas}) - $signed({1'b0, trk});
    step = diff >>> SMOOTH_SH;
    sum  = $signed({2'b00, trk}) + $signed({step[DW-1], step});
    if (sum[SW-1])                            return '0;
    else if (sum > $signed({2'b00, maxv}))    return maxv;
    else                                      return sum[CW-1:0];
  endfunction

  // Frame event, measurement qualification and reference comparisons
  assign fe        = i_vsync & ~vsync_d_q;
  assign hit       = (i_p_sum >= MIN_A_S) && (i_p_sum <= MAX_A_S) &&
                     (i_mid_x >= 32'sd0) && (i_mid_x < IMG_W_S) &&
                     (i_mid_y >= 32'sd0) && (i_mid_y < IMG_H_S);
  assign meas_x    = i_mid_x[CW-1:0];
  assign meas_y    = i_mid_y[CW-1:0];
  assign near_cand = hit && near_f(meas_x, cand_x_q) && near_f(meas_y, cand_y_q);
  assign near_trk  = hit && near_f(meas_x, trk_x_q) && near_f(meas_y, trk_y_q);
  assign iir_x     = iir_f(trk_x_q, meas_x, X_MAX);
  assign iir_y     = iir_f(trk_y_q, meas_y, Y_MAX);

  // Tracking state machine with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      vsync_d_q   <= 1'b1;
      cand_x_q    <= '0;
      cand_y_q    <= '0;
      trk_x_q     <= '0;
      trk_y_q     <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      frame_cnt_q <= '0;
      valid_q     <= 1'b0;
      lost_q      <= 1'b0;
      clear_q     <= 1'b0;
    end else begin
      vsync_d_q <= i_vsync;
      lost_q    <= 1'b0;
      clear_q   <= 1'b0;
      if (i_enable && fe) frame_cnt_q <= frame_cnt_q + FCW'(1);
      if (!i_enable) begin
        state_q    <= ST_IDLE;
        cand_x_q   <= '0;
        cand_y_q   <= '0;
        trk_x_q    <= '0;
        trk_y_q    <= '0;
        hit_cnt_q  <= '0;
        miss_cnt_q <= '0;
        valid_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_SEARCH;
            clear_q <= 1'b1;
          end
          ST_SEARCH: begin
            if (fe && hit) begin
              cand_x_q  <= meas_x;
              cand_y_q  <= meas_y;
              hit_cnt_q <= HCW'(1);
              state_q   <= ST_CONFIRM;
            end
          end
          ST_CONFIRM: begin
            if (fe) begin
              if (near_cand) begin
                cand_x_q  <= meas_x;
                cand_y_q  <= meas_y;
                hit_cnt_q <= hit_cnt_q + HCW'(1);
                if (hit_cnt_q + HCW'(1) == HIT_LAST) begin
                  trk_x_q <= meas_x;
                  trk_y_q <= meas_y;
                  valid_q <= 1'b1;
                  state_q <= ST_LOCK;
                end
              end else begin
                hit_cnt_q <= '0;
                state_q   <= ST_SEARCH;
              end
            end
          end
          ST_LOCK: begin
            if (fe) begin
              if (near_trk) begin
                trk_x_q <= iir_x;
                trk_y_q <= iir_y;
              end else begin
                miss_cnt_q <= MCW'(1);
                state_q    <= ST_COAST;
              end
            end
          end
          ST_COAST: begin
            if (fe) begin
              if (near_trk) begin
                trk_x_q    <= iir_x;
                trk_y_q    <= iir_y;
                miss_cnt_q <= '0;
                state_q    <= ST_LOCK;
              end else if (miss_cnt_q + MCW'(1) == MISS_END) begin
                miss_cnt_q <= '0;
                hit_cnt_q  <= '0;
                valid_q    <= 1'b0;
                lost_q     <= 1'b1;
                clear_q    <= 1'b1;
                state_q    <= ST_SEARCH;
              end else begin
                miss_cnt_q <= miss_cnt_q + MCW'(1);
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_trk_x      = trk_x_q;
  assign o_trk_y      = trk_y_q;
  assign o_trk_valid  = valid_q;
  assign o_state      = state_q;
  assign o_lost_pulse = lost_q;
  assign o_det_clear  = clear_q;
  assign o_frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_object_track_ctrl.sv
// tb_object_track_ctrl: scenario tasks plus randomized frames against a per-frame behavioural model.
module tb_object_track_ctrl;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_enable;
  logic               i_vsync;
  logic signed [31:0] i_mid_x;
  logic signed [31:0] i_mid_y;
  logic signed [31:0] i_p_sum;
  logic [10:0]        o_trk_x;
  logic [10:0]        o_trk_y;
  logic               o_trk_valid;
  logic [2:0]         o_state;
  logic               o_lost_pulse;
  logic               o_det_clear;
  logic [15:0]        o_frame_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural track model, advanced once per frame event
  int m_state, m_cx, m_cy, m_hit, m_miss, m_tx, m_ty, m_cnt;
  bit m_clr, m_lost;

  object_track_ctrl dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_vsync(i_vsync),
    .i_mid_x(i_mid_x), .i_mid_y(i_mid_y), .i_p_sum(i_p_sum),
    .o_trk_x(o_trk_x), .o_trk_y(o_trk_y), .o_trk_valid(o_trk_valid),
    .o_state(o_state), .o_lost_pulse(o_lost_pulse), .o_det_clear(o_det_clear),
    .o_frame_cnt(o_frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // floor((m - t) / 4) step, then clamp to the image
  function automatic int smooth(input int t, input int m, input int maxv);
    int d, st, r;
    d  = m - t;
    st = (d >= 0) ? d / 4 : -((-d + 3) / 4);
    r  = t + st;
    if (r < 0) r = 0;
    if (r > maxv) r = maxv;
    return r;
  endfunction

  task automatic model_reset();
    m_state = 0; m_cx = 0; m_cy = 0; m_hit = 0; m_miss = 0;
    m_tx = 0; m_ty = 0; m_cnt = 0; m_clr = 0; m_lost = 0;
  endtask

  task automatic model_disable();
    m_state = 0; m_hit = 0; m_miss = 0; m_tx = 0; m_ty = 0;
    m_cx = 0; m_cy = 0; m_clr = 0; m_lost = 0;
  endtask

  task automatic model_fe(input int x, input int y, input int p);
    bit hit, near;
    m_clr  = 0;
    m_lost = 0;
    m_cnt  = (m_cnt + 1) % 65536;
    hit = (p >= 64) && (p <= 16000) && (x >= 0) && (x < 200) && (y >= 0) && (y < 164);
    case (m_state)
      1: if (hit) begin m_cx = x; m_cy = y; m_hit = 1; m_state = 2; end
      2: begin
        near = hit && iabs(x - m_cx) <= 32 && iabs(y - m_cy) <= 32;
        if (near) begin
          m_cx = x; m_cy = y; m_hit++;
          if (m_hit == 3) begin m_tx = x; m_ty = y; m_state = 3; end
        end else begin
          m_hit = 0; m_state = 1;
        end
      end
      3, 4: begin
        near = hit && iabs(x - m_tx) <= 32 && iabs(y - m_ty) <= 32;
        if (near) begin
          m_tx = smooth(m_tx, x, 199); m_ty = smooth(m_ty, y, 163);
          m_miss = 0; m_state = 3;
        end else if (m_state == 3) begin
          m_miss = 1; m_state = 4;
        end else begin
          m_miss++;
          if (m_miss == 4) begin
            m_miss = 0; m_hit = 0; m_state = 1; m_lost = 1; m_clr = 1;
          end
        end
      end
      default: ;
    endcase
  endtask

  // One frame: a low vsync cycle, then a rising edge carrying the measurement
  task automatic do_frame(input int x, input int y, input int p, input bit en);
    @(negedge clk);
    i_vsync = 1'b0;
    @(negedge clk);
    i_mid_x = x; i_mid_y = y; i_p_sum = p; i_enable = en; i_vsync = 1'b1;
    @(posedge clk);
    if (en) model_fe(x, y, p); else model_disable();
    #1;
  endtask

  task automatic enable_step();
    @(negedge clk);
    i_vsync = 1'b0; i_enable = 1'b1;
    @(posedge clk);
    m_state = 1; m_clr = 1; m_lost = 0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_enable = 1'b1; i_vsync = 1'b1;
    i_mid_x = 0; i_mid_y = 0; i_p_sum = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({o_trk_x, o_trk_y, o_trk_valid, o_state, o_lost_pulse, o_det_clear, o_frame_cnt} !== 44'd0) begin
      errors++;
      $display("FAIL reset_outputs got state=%0d trk=(%0d,%0d) v=%0d lost=%0d clr=%0d cnt=%0d exp all 0",
               o_state, o_trk_x, o_trk_y, o_trk_valid, o_lost_pulse, o_det_clear, o_frame_cnt);
    end
    // vsync already high when reset releases must not count as a frame
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    m_state = 1;
    checks += 3;
    if (o_state !== 3'd1) begin errors++; $display("FAIL reset_enable_state got %0d exp 1", o_state); end
    if (o_det_clear !== 1'b1) begin errors++; $display("FAIL reset_enable_clear got %0d exp 1", o_det_clear); end
    if (o_frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_no_fe got %0d exp 0", o_frame_cnt); end
    @(posedge clk);
    #1;
    checks += 2;
    if (o_det_clear !== 1'b0) begin errors++; $display("FAIL reset_clear_width got %0d exp 0", o_det_clear); end
    if (o_frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_no_fe2 got %0d exp 0", o_frame_cnt); end
  endtask

  task automatic test_acquire();
    int exp_st[3] = '{2, 2, 3};
    for (int k = 0; k < 3; k++) begin
      do_frame(100, 80, 400, 1'b1);
      checks += 2;
      if (o_state !== 3'(exp_st[k])) begin
        errors++; $display("FAIL acquire_state frame %0d got %0d exp %0d", k, o_state, exp_st[k]);
      end
      if (o_state !== 3'(m_state)) begin
        errors++; $display("FAIL acquire_model frame %0d got %0d exp %0d", k, o_state, m_state);
      end
    end
    checks += 4;
    if (o_trk_x !== 11'd100) begin errors++; $display("FAIL acquire_trk_x got %0d exp 100", o_trk_x); end
    if (o_trk_y !== 11'd80) begin errors++; $display("FAIL acquire_trk_y got %0d exp 80", o_trk_y); end
    if (o_trk_valid !== 1'b1) begin errors++; $display("FAIL acquire_valid got %0d exp 1", o_trk_valid); end
    if (o_frame_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL acquire_cnt got %0d exp %0d", o_frame_cnt, m_cnt); end
  endtask

  task automatic test_iir_step();
    do_frame(120, 80, 400, 1'b1);
    checks += 3;
    if (o_trk_x !== 11'd105) begin errors++; $display("FAIL iir_x got %0d exp 105", o_trk_x); end
    if (o_trk_y !== 11'd80) begin errors++; $display("FAIL iir_y got %0d exp 80", o_trk_y); end
    if (o_state !== 3'd3) begin errors++; $display("FAIL iir_state got %0d exp 3", o_state); end
  endtask

  task automatic test_lost();
    int exp_st[4] = '{4, 4, 4, 1};
    for (int k = 0; k < 4; k++) begin
      do_frame(105, 80, 10, 1'b1);
      checks += 3;
      if (o_state !== 3'(exp_st[k])) begin
        errors++; $display("FAIL lost_state frame %0d got %0d exp %0d", k, o_state, exp_st[k]);
      end
      if (o_lost_pulse !== (k == 3)) begin
        errors++; $display("FAIL lost_pulse frame %0d got %0d exp %0d", k, o_lost_pulse, k == 3);
      end
      if (o_det_clear !== (k == 3)) begin
        errors++; $display("FAIL lost_clear frame %0d got %0d exp %0d", k, o_det_clear, k == 3);
      end
    end
    checks++;
    if (o_trk_valid !== 1'b0) begin errors++; $display("FAIL lost_valid got %0d exp 0", o_trk_valid); end
    @(posedge clk);
    #1;
    m_clr = 0; m_lost = 0;
    checks += 3;
    if (o_lost_pulse !== 1'b0) begin errors++; $display("FAIL lost_pulse_width got %0d exp 0", o_lost_pulse); end
    if (o_det_clear !== 1'b0) begin errors++; $display("FAIL lost_clear_width got %0d exp 0", o_det_clear); end
    if (o_trk_valid !== 1'b0) begin errors++; $display("FAIL lost_valid_after got %0d exp 0", o_trk_valid); end
  endtask

  task automatic test_far_hit();
    int exp_st[5] = '{2, 1, 2, 2, 3};
    int xs[5]     = '{50, 90, 90, 90, 90};
    for (int k = 0; k < 5; k++) begin
      do_frame(xs[k], 50, 400, 1'b1);
      checks += 2;
      if (o_state !== 3'(exp_st[k])) begin
        errors++; $display("FAIL far_state step %0d got %0d exp %0d", k, o_state, exp_st[k]);
      end
      if (o_det_clear !== 1'b0) begin
        errors++; $display("FAIL far_no_clear step %0d got %0d exp 0", k, o_det_clear);
      end
    end
  endtask

  task automatic test_disable_on_fe();
    do_frame(90, 50, 400, 1'b0);
    checks += 5;
    if (o_state !== 3'd0) begin errors++; $display("FAIL dis_state got %0d exp 0", o_state); end
    if (o_trk_x !== 11'd0) begin errors++; $display("FAIL dis_trk_x got %0d exp 0", o_trk_x); end
    if (o_trk_y !== 11'd0) begin errors++; $display("FAIL dis_trk_y got %0d exp 0", o_trk_y); end
    if (o_trk_valid !== 1'b0) begin errors++; $display("FAIL dis_valid got %0d exp 0", o_trk_valid); end
    if (o_frame_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL dis_cnt got %0d exp %0d", o_frame_cnt, m_cnt); end
    enable_step();
    checks += 2;
    if (o_state !== 3'd1) begin errors++; $display("FAIL reen_state got %0d exp 1", o_state); end
    if (o_det_clear !== 1'b1) begin errors++; $display("FAIL reen_clear got %0d exp 1", o_det_clear); end
  endtask

  task automatic test_frame_wrap();
    int exp_cnt[2] = '{65535, 0};
    @(negedge clk);
    i_vsync = 1'b0;
    force dut.frame_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.frame_cnt_q;
    m_cnt = 65534;
    for (int k = 0; k < 2; k++) begin
      do_frame(10, 10, 5, 1'b1);
      checks++;
      if (o_frame_cnt !== 16'(exp_cnt[k])) begin
        errors++; $display("FAIL wrap_cnt step %0d got %0h exp %0h", k, o_frame_cnt, exp_cnt[k]);
      end
    end
  endtask

  task automatic test_random();
    int bx = 100, by = 80;
    int x, y, p;
    bit en;
    for (int i = 0; i < 220; i++) begin
      en = ($urandom_range(0, 99) >= 3);
      case ($urandom_range(0, 9))
        0: p = 63;
        1: p = 16001;
        2: p = -int'($urandom_range(1, 1000));
        3: p = $urandom_range(0, 63);
        4: p = 64;
        5: p = 16000;
        default: p = $urandom_range(64, 16000);
      endcase
      bx = bx + int'($urandom_range(0, 12)) - 6;
      by = by + int'($urandom_range(0, 12)) - 6;
      if (bx < 0) bx = 0;
      if (bx > 199) bx = 199;
      if (by < 0) by = 0;
      if (by > 163) by = 163;
      case ($urandom_range(0, 11))
        0: x = 199;
        1: x = 200;
        2: x = -int'($urandom_range(1, 5));
        default: x = bx + int'($urandom_range(0, 72)) - 36;
      endcase
      case ($urandom_range(0, 11))
        0: y = 163;
        1: y = 164;
        2: y = -int'($urandom_range(1, 5));
        default: y = by + int'($urandom_range(0, 72)) - 36;
      endcase
      do_frame(x, y, p, en);
      checks += 7;
      if (o_state !== 3'(m_state)) begin
        errors++; $display("FAIL rnd_state frame %0d got %0d exp %0d", i, o_state, m_state);
      end
      if (o_trk_x !== 11'(m_tx)) begin
        errors++; $display("FAIL rnd_trk_x frame %0d got %0d exp %0d", i, o_trk_x, m_tx);
      end
      if (o_trk_y !== 11'(m_ty)) begin
        errors++; $display("FAIL rnd_trk_y frame %0d got %0d exp %0d", i, o_trk_y, m_ty);
      end
      if (o_trk_valid !== (m_state == 3 || m_state == 4)) begin
        errors++; $display("FAIL rnd_valid frame %0d got %0d exp %0d", i, o_trk_valid, m_state == 3 || m_state == 4);
      end
      if (o_lost_pulse !== m_lost) begin
        errors++; $display("FAIL rnd_lost frame %0d got %0d exp %0d", i, o_lost_pulse, m_lost);
      end
      if (o_det_clear !== m_clr) begin
        errors++; $display("FAIL rnd_clear frame %0d got %0d exp %0d", i, o_det_clear, m_clr);
      end
      if (o_frame_cnt !== 16'(m_cnt)) begin
        errors++; $display("FAIL rnd_cnt frame %0d got %0d exp %0d", i, o_frame_cnt, m_cnt);
      end
      if (!en) begin
        enable_step();
        checks += 2;
        if (o_state !== 3'd1) begin errors++; $display("FAIL rnd_reen_state frame %0d got %0d exp 1", i, o_state); end
        if (o_det_clear !== 1'b1) begin errors++; $display("FAIL rnd_reen_clear frame %0d got %0d exp 1", i, o_det_clear); end
      end else if ($urandom_range(0, 2) == 0) begin
        // vsync held high with changing inputs: no second frame event
        repeat (2) begin
          @(negedge clk);
          i_mid_x = bx; i_mid_y = by; i_p_sum = 400;
          @(posedge clk);
          #1;
        end
        m_clr = 0; m_lost = 0;
        checks += 4;
        if (o_frame_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL hold_cnt frame %0d got %0d exp %0d", i, o_frame_cnt, m_cnt); end
        if (o_state !== 3'(m_state)) begin errors++; $display("FAIL hold_state frame %0d got %0d exp %0d", i, o_state, m_state); end
        if (o_det_clear !== 1'b0) begin errors++; $display("FAIL hold_clear frame %0d got %0d exp 0", i, o_det_clear); end
        if (o_lost_pulse !== 1'b0) begin errors++; $display("FAIL hold_lost frame %0d got %0d exp 0", i, o_lost_pulse); end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) do_frame(60, 60, 500, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({o_trk_x, o_trk_y, o_trk_valid, o_state, o_lost_pulse, o_det_clear, o_frame_cnt} !== 44'd0) begin
      errors++;
      $display("FAIL reset_mid got state=%0d trk=(%0d,%0d) v=%0d cnt=%0d exp all 0",
               o_state, o_trk_x, o_trk_y, o_trk_valid, o_frame_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    i_vsync = 1'b0;
    @(posedge clk);
    #1;
    m_state = 1;
    checks += 2;
    if (o_state !== 3'd1) begin errors++; $display("FAIL reset_mid_resume got %0d exp 1", o_state); end
    if (o_det_clear !== 1'b1) begin errors++; $display("FAIL reset_mid_clear got %0d exp 1", o_det_clear); end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_iir_step();
    test_lost();
    test_far_hit();
    test_disable_on_fe();
    test_frame_wrap();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
